// File: rtl/am2302_pkg.sv
// Shared definitions for the AM2302 single-wire host: FSM encoding,
// frame layout, default timing and the frame checksum helpers.
package am2302_pkg;

    // FSM states, 4-bit encoding
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_WAIT_ACK  = 4'd2,
        ST_ACK_LOW   = 4'd3,
        ST_ACK_HIGH  = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_STOP_LOW  = 4'd7,
        ST_FINISH    = 4'd8,
        ST_GAP       = 4'd9
    } state_t;

    // Frame layout: humidity word, temperature word, checksum byte (MSB first)
    localparam int FRAME_BITS = 40;
    localparam int BIT_IDX_W  = 6;
    localparam int HUM_HI_LSB = 32;
    localparam int HUM_LO_LSB = 24;
    localparam int TMP_HI_LSB = 16;
    localparam int TMP_LO_LSB = 8;
    localparam int CHK_LSB    = 0;

    // Microsecond counter width (saturating, covers the 2000us gap)
    localparam int US_CNT_W = 11;

    // Default timing
    localparam int DEF_CLKS_PER_US   = 50;
    localparam int DEF_START_LOW_US  = 1000;
    localparam int DEF_TIMEOUT_US    = 200;
    localparam int DEF_BIT_THRESH_US = 48;
    localparam int DEF_GAP_US        = 2000;

    // Sum of the four data bytes, modulo 256
    function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[HUM_HI_LSB +: 8] + frame[HUM_LO_LSB +: 8]
            + frame[TMP_HI_LSB +: 8] + frame[TMP_LO_LSB +: 8];
        return sum;
    endfunction

    // True when the trailing checksum byte matches the data bytes
    function automatic logic frame_checksum_ok(input logic [FRAME_BITS-1:0] frame);
        return (frame[CHK_LSB +: 8] == frame_sum(frame));
    endfunction

endpackage

// File: rtl/am2302_us_timer.sv
// Microsecond time base: prescaler producing us_tick once per CLKS_PER_US
// clocks and a saturating microsecond counter; clr restarts both.
module am2302_us_timer
    import am2302_pkg::*;
#(
    parameter int CLKS_PER_US = DEF_CLKS_PER_US
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                us_tick,
    output logic [US_CNT_W-1:0] us_cnt
);

    localparam int                  PRE_W   = $clog2(CLKS_PER_US);
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(CLKS_PER_US - 1);
    localparam logic [US_CNT_W-1:0] CNT_MAX = {US_CNT_W{1'b1}};

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [US_CNT_W-1:0] us_cnt_r;
    logic                us_tick_r;

    // Prescaler and saturating counter; tick and count advance on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            us_cnt_r  <= {US_CNT_W{1'b0}};
            us_tick_r <= 1'b0;
        end else if (clr) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            us_cnt_r  <= {US_CNT_W{1'b0}};
            us_tick_r <= 1'b0;
        end else if (pre_cnt_r == PRE_MAX) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            us_tick_r <= 1'b1;
            if (us_cnt_r != CNT_MAX) begin
                us_cnt_r <= us_cnt_r + US_CNT_W'(1);
            end else begin
                us_cnt_r <= us_cnt_r;
            end
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            us_tick_r <= 1'b0;
        end
    end

    assign us_tick = us_tick_r;
    assign us_cnt  = us_cnt_r;

endmodule

// File: rtl/am2302_host_ctrl.sv
// AM2302 single-wire host: issues the wake pulse, follows the sensor
// handshake, decodes 40 bits by high-pulse width and validates the checksum.
// SDA is open-drain: the host only ever pulls low or releases the line.
module am2302_host_ctrl
    import am2302_pkg::*;
#(
    parameter int CLKS_PER_US   = DEF_CLKS_PER_US,
    parameter int START_LOW_US  = DEF_START_LOW_US,
    parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
    parameter int GAP_US        = DEF_GAP_US
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] rh_data,
    output logic [15:0] t_data,
    output logic        chksum_err,
    output logic        timeout_err,
    inout  wire         sda
);

    localparam logic [US_CNT_W-1:0]  START_LOW_CNT  = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0]  TIMEOUT_CNT    = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0]  BIT_THRESH_CNT = US_CNT_W'(BIT_THRESH_US);
    localparam logic [US_CNT_W-1:0]  GAP_CNT        = US_CNT_W'(GAP_US);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX   = BIT_IDX_W'(FRAME_BITS - 1);

    state_t                state_r;
    state_t                state_next_s;
    logic                  sda_meta_r;
    logic                  sda_sync_r;
    logic                  sda_prev_r;
    logic                  sda_rise_s;
    logic                  sda_fall_s;
    logic                  us_tick_s;
    logic                  us_clr_s;
    logic [US_CNT_W-1:0]   us_cnt_s;
    logic                  sensor_phase_s;
    logic                  timeout_s;
    logic                  fin_timeout_s;
    logic                  shift_en_s;
    logic                  load_idx_s;
    logic                  bit_val_s;
    logic                  enter_finish_s;
    logic                  frame_ok_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [BIT_IDX_W-1:0]  bit_idx_r;
    logic                  sda_oe_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  chk_err_r;
    logic                  to_err_r;
    logic [15:0]           rh_r;
    logic [15:0]           t_r;

    // Open-drain pad: pull low or float, never drive high
    assign sda = sda_oe_r ? 1'b0 : 1'bz;

    am2302_us_timer #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_us_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (us_clr_s),
        .us_tick (us_tick_s),
        .us_cnt  (us_cnt_s)
    );

    assign sda_rise_s     = sda_sync_r & ~sda_prev_r;
    assign sda_fall_s     = ~sda_sync_r & sda_prev_r;
    assign sensor_phase_s = state_r inside {ST_WAIT_ACK, ST_ACK_LOW, ST_ACK_HIGH,
                                            ST_BIT_LOW, ST_BIT_HIGH, ST_STOP_LOW};
    // Counter is cleared on entry, so a tick with the target value marks the moment it is reached
    assign timeout_s      = sensor_phase_s && us_tick_s && (us_cnt_s == TIMEOUT_CNT);
    assign bit_val_s      = (us_cnt_s > BIT_THRESH_CNT);
    assign us_clr_s       = (state_next_s != state_r);
    assign enter_finish_s = (state_next_s == ST_FINISH) && (state_r != ST_FINISH);
    assign frame_ok_s     = frame_checksum_ok(shift_r);

    // Two-flop synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a timeout in any sensor-driven phase overrides the handshake
    always_comb begin
        state_next_s  = state_r;
        fin_timeout_s = 1'b0;
        shift_en_s    = 1'b0;
        load_idx_s    = 1'b0;
        if (timeout_s) begin
            state_next_s  = ST_FINISH;
            fin_timeout_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_next_s = ST_START_LOW;
                    else       state_next_s = ST_IDLE;
                end
                ST_START_LOW: begin
                    if (us_tick_s && (us_cnt_s == START_LOW_CNT)) state_next_s = ST_WAIT_ACK;
                    else                                          state_next_s = ST_START_LOW;
                end
                ST_WAIT_ACK: begin
                    if (sda_fall_s) state_next_s = ST_ACK_LOW;
                    else            state_next_s = ST_WAIT_ACK;
                end
                ST_ACK_LOW: begin
                    if (sda_rise_s) state_next_s = ST_ACK_HIGH;
                    else            state_next_s = ST_ACK_LOW;
                end
                ST_ACK_HIGH: begin
                    if (sda_fall_s) begin
                        state_next_s = ST_BIT_LOW;
                        load_idx_s   = 1'b1;
                    end else begin
                        state_next_s = ST_ACK_HIGH;
                    end
                end
                ST_BIT_LOW: begin
                    if (sda_rise_s) state_next_s = ST_BIT_HIGH;
                    else            state_next_s = ST_BIT_LOW;
                end
                ST_BIT_HIGH: begin
                    if (sda_fall_s) begin
                        shift_en_s = 1'b1;
                        if (bit_idx_r == BIT_IDX_W'(0)) state_next_s = ST_STOP_LOW;
                        else                            state_next_s = ST_BIT_LOW;
                    end else begin
                        state_next_s = ST_BIT_HIGH;
                    end
                end
                ST_STOP_LOW: begin
                    if (sda_rise_s) state_next_s = ST_FINISH;
                    else            state_next_s = ST_STOP_LOW;
                end
                ST_FINISH: begin
                    state_next_s = ST_GAP;
                end
                ST_GAP: begin
                    if (us_tick_s && (us_cnt_s == GAP_CNT)) state_next_s = ST_IDLE;
                    else                                    state_next_s = ST_GAP;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Frame shift register (MSB first) and remaining-bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {FRAME_BITS{1'b0}};
            bit_idx_r <= {BIT_IDX_W{1'b0}};
        end else if (load_idx_s) begin
            shift_r   <= shift_r;
            bit_idx_r <= LAST_BIT_IDX;
        end else if (shift_en_s) begin
            shift_r   <= {shift_r[FRAME_BITS-2:0], bit_val_s};
            bit_idx_r <= bit_idx_r - BIT_IDX_W'(1);
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Pad enable and BUSY follow the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            sda_oe_r <= (state_next_s == ST_START_LOW);
            busy_r   <= (state_next_s != ST_IDLE);
        end
    end

    // Result registers: captured on entry to FINISH, so DONE is high only in FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r    <= 1'b0;
            chk_err_r <= 1'b0;
            to_err_r  <= 1'b0;
            rh_r      <= 16'h0000;
            t_r       <= 16'h0000;
        end else if (enter_finish_s) begin
            done_r <= 1'b1;
            if (fin_timeout_s) begin
                to_err_r  <= 1'b1;
                chk_err_r <= 1'b0;
            end else if (frame_ok_s) begin
                to_err_r  <= 1'b0;
                chk_err_r <= 1'b0;
                rh_r      <= shift_r[HUM_LO_LSB +: 16];
                t_r       <= shift_r[TMP_LO_LSB +: 16];
            end else begin
                to_err_r  <= 1'b0;
                chk_err_r <= 1'b1;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign rh_data     = rh_r;
    assign t_data      = t_r;
    assign chksum_err  = chk_err_r;
    assign timeout_err = to_err_r;

endmodule
